// File: rtl/led_pkg.sv
// Shared encodings and helpers for the LED pattern engine.
// Used by led_pattern_engine and its testbench.
package led_pkg;

  localparam logic [1:0] MODE_ROT_L  = 2'd0;
  localparam logic [1:0] MODE_ROT_R  = 2'd1;
  localparam logic [1:0] MODE_BOUNCE = 2'd2;
  localparam logic [1:0] MODE_HOLD   = 2'd3;

  typedef enum logic {
    DIR_LEFT  = 1'b0,
    DIR_RIGHT = 1'b1
  } dir_t;

  // Clock cycles per pattern step, never below one.
  function automatic int calc_tick_div(input int clk_freq,
                                       input int steps_per_sec);
    int d;
    d = (steps_per_sec > 0) ? clk_freq / steps_per_sec : 1;
    return (d < 1) ? 1 : d;
  endfunction

endpackage

// File: rtl/step_prescaler.sv
// Free-running step prescaler: pulses tick every TICK_DIV enabled cycles.
// clr restarts the interval so the next tick is a full period away.
module step_prescaler #(
  parameter int TICK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt;

  assign tick = en && (cnt == LAST);

  // Interval counter; frozen while paused, cleared by reset or load.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (en) begin
      if (cnt == LAST) cnt <= '0;
      else             cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/led_pattern_engine.sv
// LED bank pattern engine: rotate / bounce / hold at a fixed step rate.
// Define LED_PATTERN_INVERT_EN to drive active-low LED pins.
module led_pattern_engine
  import led_pkg::*;
#(
  parameter int               WIDTH         = 8,
  parameter int               CLK_FREQ      = 25_000_000,
  parameter int               STEPS_PER_SEC = 4,
  parameter logic [WIDTH-1:0] INIT_PATTERN  = WIDTH'(8'b0001_1111)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic             load,
  input  logic [WIDTH-1:0] load_pattern,
  output logic [WIDTH-1:0] leds,
  output logic             step
);

  localparam int TICK_DIV = calc_tick_div(CLK_FREQ, STEPS_PER_SEC);

  logic [WIDTH-1:0] pat;
  logic [WIDTH-1:0] pat_nxt;
  dir_t             dir;
  dir_t             dir_nxt;
  logic             tick;

  step_prescaler #(
    .TICK_DIV (TICK_DIV)
  ) u_pre (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .clr  (load),
    .tick (tick)
  );

  // Next pattern and direction for a step tick, chosen by mode.
  always_comb begin
    pat_nxt = pat;
    dir_nxt = dir;
    unique case (mode)
      MODE_ROT_L: pat_nxt = {pat[WIDTH-2:0], pat[WIDTH-1]};
      MODE_ROT_R: pat_nxt = {pat[0], pat[WIDTH-1:1]};
      MODE_BOUNCE: begin
        if (pat == '0 || (pat[WIDTH-1] && pat[0])) begin
          pat_nxt = pat;
        end else if (dir == DIR_LEFT) begin
          if (!pat[WIDTH-1]) begin
            pat_nxt = pat << 1;
          end else begin
            dir_nxt = DIR_RIGHT;
            pat_nxt = pat >> 1;
          end
        end else begin
          if (!pat[0]) begin
            pat_nxt = pat >> 1;
          end else begin
            dir_nxt = DIR_LEFT;
            pat_nxt = pat << 1;
          end
        end
      end
      MODE_HOLD: pat_nxt = pat;
    endcase
  end

  // Pattern, direction and step pulse registers: rst > load > tick.
  always_ff @(posedge clk) begin
    if (rst) begin
      pat  <= INIT_PATTERN;
      dir  <= DIR_LEFT;
      step <= 1'b0;
    end else if (load) begin
      pat  <= load_pattern;
      dir  <= DIR_LEFT;
      step <= 1'b0;
    end else if (tick) begin
      pat  <= pat_nxt;
      dir  <= dir_nxt;
      step <= 1'b1;
    end else begin
      step <= 1'b0;
    end
  end

`ifdef LED_PATTERN_INVERT_EN
  assign leds = ~pat;
`else
  assign leds = pat;
`endif

endmodule
